// File: rtl/pushbutton_debounce_pkg.sv
// +----------------------------------------------------------------------------+
// | pushbutton_debounce_pkg                                                    |
// | Shared state encoding and width helper for the push-button debouncer.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pushbutton_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    HELD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } debounce_state_t;

  // Bits needed to hold values 0..max_count; never narrower than one bit.
  function automatic int CNT_W(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage : pushbutton_debounce_pkg

`default_nettype wire

// File: rtl/input_synchronizer.sv
// +----------------------------------------------------------------------------+
// | input_synchronizer                                                         |
// | SYNC_STAGES-deep flop chain bringing an asynchronous level into clk.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module input_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule : input_synchronizer

`default_nettype wire

// File: rtl/pushbutton_debounce.sv
// +----------------------------------------------------------------------------+
// | pushbutton_debounce                                                        |
// | Synchronizes and debounces a push-button; registered level, press and      |
// | release strobes. Define PUSHBUTTON_AUTOREPEAT_EN for held-key auto-repeat. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pushbutton_debounce
  import pushbutton_debounce_pkg::*;
#(
  parameter int SYNC_STAGES          = 2,
  parameter int DEBOUNCE_CYCLES      = 16,
  parameter int REPEAT_DELAY_CYCLES  = 64,
  parameter int REPEAT_PERIOD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int                 c_CNT_W   = CNT_W(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("pushbutton_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("pushbutton_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_chk_repeat
    $error("pushbutton_debounce: repeat delay and period must be at least 1");
  end

  logic            w_s;
  debounce_state_t r_state;
  debounce_state_t w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic            r_level;
  logic            w_level_nxt;
  logic            r_press;
  logic            w_press_nxt;
  logic            r_release;
  logic            w_release_nxt;
  logic            w_rpt_fire;

  input_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (reset),
    .i_async (btn_raw),
    .o_sync  (w_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Strobes are computed from the transition and registered with the state,
  // so they line up exactly with the cycle btn_level changes.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = c_CNT_ONE;
        end else begin
          w_press_nxt = w_rpt_fire;
        end
      end
      WAIT_RELEASE: begin
        if (w_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PUSHBUTTON_AUTOREPEAT_EN
  localparam int c_RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int                 c_RPT_W          = CNT_W(c_RPT_MAX);
  localparam logic [c_RPT_W-1:0] c_RPT_DELAY_LAST = c_RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_RPT_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  logic [c_RPT_W-1:0] r_rpt_cnt;
  logic               r_rpt_periodic;
  logic [c_RPT_W-1:0] w_rpt_last;

  assign w_rpt_last = r_rpt_periodic ? c_RPT_PERIOD_LAST : c_RPT_DELAY_LAST;
  assign w_rpt_fire = (r_state == HELD) && w_s && (r_rpt_cnt == w_rpt_last);

  // Counts only while HELD persists; any other cycle restarts the delay phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt_cnt      <= '0;
      r_rpt_periodic <= 1'b0;
    end else if (r_state == HELD && w_state_nxt == HELD) begin
      if (w_rpt_fire) begin
        r_rpt_cnt      <= '0;
        r_rpt_periodic <= 1'b1;
      end else begin
        r_rpt_cnt      <= r_rpt_cnt + c_RPT_W'(1);
      end
    end else begin
      r_rpt_cnt      <= '0;
      r_rpt_periodic <= 1'b0;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule : pushbutton_debounce

`default_nettype wire

// File: tb/tb_pushbutton_debounce.sv
// +----------------------------------------------------------------------------+
// | tb_pushbutton_debounce                                                     |
// | Directed bench: DEBOUNCE_CYCLES=4 (repeat 8/4) and DEBOUNCE_CYCLES=1 DUTs. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pushbutton_debounce;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic btn1;
  logic level, press, release_p;
  logic level1, press1, release1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pushbutton_debounce #(
    .SYNC_STAGES          (2),
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (8),
    .REPEAT_PERIOD_CYCLES (4)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn),
    .btn_level     (level),
    .press_pulse   (press),
    .release_pulse (release_p)
  );

  pushbutton_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1)
  ) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn1),
    .btn_level     (level1),
    .press_pulse   (press1),
    .release_pulse (release1)
  );

  // Returns #1 after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps u_dut n cycles, counting strobe and level-high cycles.
  task automatic run(input int n, output int pc, output int rc, output int lc);
    pc = 0; rc = 0; lc = 0;
    repeat (n) begin
      tick();
      pc += int'(press);
      rc += int'(release_p);
      lc += int'(level);
    end
  endtask

  initial begin
    int p, r, l, p2, r2, l2;
    logic pat [6];
    logic [39:0] pv, rv, exp_pv, exp_rv;

    reset = 1'b1; btn = 1'b0; btn1 = 1'b0;
    tick(); tick();
    check("rst_level", level, 1'b0);
    check("rst_press", press, 1'b0);
    check("rst_release", release_p, 1'b0);
    check("rst_level1", level1, 1'b0);
    reset = 1'b0;
    repeat (3) tick();

    // Clean press: accepted at edge 6.
    btn = 1'b1;
    run(6, p, r, l);
    check("s1_no_early_press", p, 0);
    check("s1_level_before", level, 1'b0);
    tick();
    check("s1_press_edge6", press, 1'b1);
    check("s1_level_edge6", level, 1'b1);
    check("s1_no_release", release_p, 1'b0);
    tick();
    check("s1_press_one_cycle", press, 1'b0);
    run(10, p, r, l);
    check("s1_release_while_held", r, 0);
    check("s1_level_held", l, 10);
    btn = 1'b0;
    run(6, p, r, l);
    check("s1_no_early_release", r, 0);
    tick();
    check("s1_release_edge6", release_p, 1'b1);
    check("s1_level_dropped", level, 1'b0);
    tick();
    check("s1_release_one_cycle", release_p, 1'b0);
    repeat (4) tick();

    // Bounce 1,0,1,1,0,1 then steady 1.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    p2 = 0;
    for (int i = 0; i < 6; i++) begin
      btn = pat[i];
      if (i < 5) begin
        tick();
        p2 += int'(press);
      end
    end
    run(6, p, r, l);
    check("s2_no_bounce_press", p + p2, 0);
    tick();
    check("s2_press_after_settle", press, 1'b1);
    tick();
    check("s2_press_one_cycle", press, 1'b0);
    check("s2_level", level, 1'b1);
    btn = 1'b0;
    run(12, p, r, l);
    check("s2_one_release", r, 1);
    check("s2_level_low", level, 1'b0);

    // Glitch of 3 cycles.
    btn = 1'b1;
    run(3, p, r, l);
    btn = 1'b0;
    run(12, p2, r2, l2);
    check("s3_glitch_press", p + p2, 0);
    check("s3_glitch_level", l + l2, 0);

    // Reset during the press qualification window.
    btn = 1'b1;
    run(4, p, r, l);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s4_rst_level", level, 1'b0);
    check("s4_rst_press", press, 1'b0);
    check("s4_rst_release", release_p, 1'b0);
    run(6, p, r, l);
    check("s4_no_stale_press", p, 0);
    tick();
    check("s4_requalified_press", press, 1'b1);
    check("s4_requalified_level", level, 1'b1);
    btn = 1'b0;
    run(12, p, r, l);
    check("s4_release", r, 1);

    // DEBOUNCE_CYCLES=1: press and release each accepted at edge 3.
    btn1 = 1'b1;
    repeat (3) tick();
    check("s5_no_early_press", press1, 1'b0);
    tick();
    check("s5_press", press1, 1'b1);
    check("s5_level_high", level1, 1'b1);
    repeat (3) tick();
    btn1 = 1'b0;
    p = 0;
    repeat (3) begin
      tick();
      p += int'(press1);
    end
    check("s5_no_early_release", release1, 1'b0);
    tick();
    p += int'(press1);
    check("s5_release", release1, 1'b1);
    check("s5_level_low", level1, 1'b0);
    tick();
    p += int'(press1);
    check("s5_release_one_cycle", release1, 1'b0);
    check("s5_no_press_on_release", p, 0);

    // Hold 30 cycles: auto-repeat pattern depends on the build.
    repeat (4) tick();
    btn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      pv[k] = press;
      rv[k] = release_p;
      if (k == 29) btn = 1'b0;
    end
    exp_pv = '0;
    exp_rv = '0;
    exp_pv[6]  = 1'b1;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
    exp_pv[14] = 1'b1;
    exp_pv[18] = 1'b1;
    exp_pv[22] = 1'b1;
    exp_pv[26] = 1'b1;
    exp_pv[30] = 1'b1;
`endif
    exp_rv[36] = 1'b1;
    check("s6_press_pattern", pv, exp_pv);
    check("s6_release_pattern", rv, exp_rv);
    check("s6_final_level", level, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pushbutton_debounce

`default_nettype wire
